// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with 3-sample vote, runtime parity/stop modes, break detect, output FIFO.
// Latency: the last stop-bit vote tick is followed by a FIFO push on the next clk; m_valid rises the clk after that.
// Backpressure: m_valid/m_ready pop; a frame that completes while the FIFO is full is dropped and pulses rx_overrun.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_baud_tick,
  input  logic                 rx_in,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_two_stop,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = DATA_BITS + 2;

  localparam logic [SC_W-1:0] TICK_SMP0 = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] TICK_SMP1 = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] TICK_VOTE = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0] TICK_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_BITS - 1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  logic                 rx_meta, rxs;
  logic [2:0]           state;
  logic [SC_W-1:0]      sample_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic                 smp0, smp1;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           par_mode;
  logic                 two_stop;
  logic                 par_bit, perr, ferr, brk, brk_hold;
  logic                 push_req, push_brk;
  logic [EW-1:0]        push_ent;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [EW-1:0]        head;

  logic at_smp0, at_smp1, at_vote, at_last;
  logic vote, par_en, brk_det, full, do_pop, do_push;

  assign at_smp0 = rx_baud_tick && (sample_cnt == TICK_SMP0);
  assign at_smp1 = rx_baud_tick && (sample_cnt == TICK_SMP1);
  assign at_vote = rx_baud_tick && (sample_cnt == TICK_VOTE);
  assign at_last = rx_baud_tick && (sample_cnt == TICK_LAST);

  assign vote    = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
  assign par_en  = ^par_mode;
  // Break: all-zero data, zero parity bit when one is present, and a low first stop bit.
  assign brk_det = (shreg == '0) && !(par_en && par_bit) && !vote;

  // Two-flop synchroniser; the line idles high so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  // Oversample counter: held at 0 in IDLE so each frame is timed from its own start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (state == S_IDLE) begin
      sample_cnt <= '0;
    end else if (rx_baud_tick) begin
      sample_cnt <= (sample_cnt == TICK_LAST) ? '0 : sample_cnt + 1'b1;
    end
  end

  // Capture the two samples that precede the voting tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else begin
      if (at_smp0) smp0 <= rxs;
      if (at_smp1) smp1 <= rxs;
    end
  end

  // Frame state machine; the completed entry is staged in push_ent for one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_mode <= 2'b00;
      two_stop <= 1'b0;
      par_bit  <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      brk      <= 1'b0;
      brk_hold <= 1'b0;
      push_req <= 1'b0;
      push_brk <= 1'b0;
      push_ent <= '0;
    end else begin
      push_req <= 1'b0;
      if (rxs) brk_hold <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs && !brk_hold) begin
            state    <= S_START;
            par_mode <= cfg_parity;
            two_stop <= cfg_two_stop;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            brk      <= 1'b0;
          end
        end
        S_START: begin
          if (at_vote && vote) begin
            state <= S_IDLE;
          end else if (at_last) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (at_last) begin
            if (bit_cnt == BIT_LAST) state <= par_en ? S_PARITY : S_STOP1;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (at_vote) begin
            par_bit <= vote;
            // Odd mode (2'b10) inverts the XOR of the data bits.
            if (vote != ((^shreg) ^ par_mode[1])) perr <= 1'b1;
          end
          if (at_last) state <= S_STOP1;
        end
        S_STOP1: begin
          if (at_vote) begin
            ferr <= ferr | !vote;
            if (brk_det) begin
              brk      <= 1'b1;
              brk_hold <= 1'b1;
            end
            // Single stop bit: finish half a bit early to resync on the next start edge.
            if (!two_stop) begin
              state    <= S_IDLE;
              push_req <= 1'b1;
              push_brk <= brk_det;
              push_ent <= {perr, ferr | !vote, shreg};
            end
          end else if (at_last && two_stop) begin
            state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (at_vote) begin
            state    <= S_IDLE;
            push_req <= 1'b1;
            push_brk <= brk;
            push_ent <= {perr, ferr | !vote, shreg};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign full       = (count == CNT_FULL);
  assign m_valid    = (count != '0);
  assign do_pop     = m_valid && m_ready;
  // A pop in the same clk frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push_req && (!full || do_pop);
  assign rx_overrun = push_req && full && !do_pop;
  assign rx_break   = push_req && push_brk;
  assign rx_busy    = (state != S_IDLE);

  // FIFO storage needs no reset; outputs are gated by m_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ent;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  assign head         = mem[rd_ptr];
  assign m_data       = m_valid ? head[DATA_BITS-1:0] : '0;
  assign m_frame_err  = m_valid && head[DATA_BITS];
  assign m_parity_err = m_valid && head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg (8 data bits, 16x oversample, 4-deep FIFO).
// Frames are built bit by bit on rx_in; expected entries are queued when each frame is issued.
// A negedge monitor pops the queue on every m_valid && m_ready handshake and counts pulses.
module tb_uart_rx_cfg;
  localparam int DB    = 8;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int TDIV  = 3;

  typedef struct packed {
    logic          perr;
    logic          ferr;
    logic [DB-1:0] data;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          tick;
  logic          rx_in;
  logic [1:0]    cfg_parity;
  logic          cfg_two_stop;
  logic          m_valid;
  logic          m_ready;
  logic [DB-1:0] m_data;
  logic          m_frame_err, m_parity_err, rx_overrun, rx_break, rx_busy;

  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   brk_cnt = 0;
  int   exp_brk = 0;
  int   valid_cyc = 0;
  bit   ready_rand = 0;
  bit   ready_val = 1;
  ent_t exp_q[$];

  uart_rx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_baud_tick (tick),
    .rx_in        (rx_in),
    .cfg_parity   (cfg_parity),
    .cfg_two_stop (cfg_two_stop),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_frame_err  (m_frame_err),
    .m_parity_err (m_parity_err),
    .rx_overrun   (rx_overrun),
    .rx_break     (rx_break),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: one clk pulse every TDIV clks.
  initial begin
    int tc;
    tc = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tick = (tc == 0);
      tc = (tc + 1) % TDIV;
    end
  end

  // Consumer ready: fixed value or random per clk.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops and pulse counters, sampled mid-cycle.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rx_overrun) ovr_cnt++;
      if (rx_break) brk_cnt++;
      if (m_valid) valid_cyc++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry: got data=%h ferr=%b perr=%b, expected no entry",
                   m_data, m_frame_err, m_parity_err);
        end else begin
          e = exp_q.pop_front();
          check("entry{perr,ferr,data}", {22'd0, m_parity_err, m_frame_err, m_data}, {22'd0, e});
        end
      end
    end
  end

  function automatic bit par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  // Parity bit a correct transmitter would send: even makes the total count of ones even.
  function automatic logic good_pbit(input logic [DB-1:0] d, input logic [1:0] p);
    int ones;
    ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    return (p == 2'b10) ? logic'(1 - ones % 2) : logic'(ones % 2);
  endfunction

  function automatic ent_t model_ent(input logic [DB-1:0] d, input logic [1:0] p, input logic ts,
                                     input logic pb, input logic s1, input logic s2);
    ent_t e;
    e.data = d;
    e.ferr = !s1 || (ts && !s2);
    e.perr = par_on(p) && (pb != good_pbit(d, p));
    return e;
  endfunction

  function automatic bit model_brk(input logic [DB-1:0] d, input logic [1:0] p,
                                   input logic pb, input logic s1);
    return (d == '0) && (!par_on(p) || !pb) && !s1;
  endfunction

  // Wait for n baud ticks, then step 2 time units past the edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do begin
        @(posedge clk);
      end while (tick !== 1'b1);
    end
    #2;
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    rx_in = v;
    if (glitch) begin
      wait_ticks(9);
      rx_in = ~v;
      wait_ticks(1);
      rx_in = v;
      wait_ticks(OS - 10);
    end else begin
      wait_ticks(OS);
    end
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    wait_ticks(OS * n);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] p, input logic ts,
                            input logic pb, input logic s1, input logic s2,
                            input int gbit, input bit expect_push);
    if (expect_push) begin
      exp_q.push_back(model_ent(d, p, ts, pb, s1, s2));
      if (model_brk(d, p, pb, s1)) exp_brk++;
    end
    wait_ticks(1);
    cfg_parity   = p;
    cfg_two_stop = ts;
    drive_bit(1'b0, 1'b0);
    // Config changes after the start edge must be ignored for this frame.
    cfg_parity   = 2'($urandom);
    cfg_two_stop = 1'($urandom);
    for (int i = 0; i < DB; i++) drive_bit(d[i], i == gbit);
    if (par_on(p)) drive_bit(pb, 1'b0);
    drive_bit(s1, 1'b0);
    if (ts) drive_bit(s2, 1'b0);
    rx_in = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #900_000;
    errors++;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, o0, b0, gap, gb;
    logic [DB-1:0] d;
    logic [1:0] p;
    logic ts, pb, s1, s2;

    rst_n = 1'b0;
    rx_in = 1'b1;
    cfg_parity = 2'b00;
    cfg_two_stop = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_flags", {m_frame_err, m_parity_err}, 0);
    check("rst_pulses", {rx_overrun, rx_break}, 0);
    check("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    idle_bits(1);

    // 8N1 0xA5 with m_ready held high: one entry, m_valid for exactly one clk.
    v0 = valid_cyc;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    idle_bits(2);
    wait_drain("drain_a5", 2000);
    check("valid_width_a5", valid_cyc - v0, 1);

    // Even parity with wrong parity bit, then odd parity where the same bit is correct.
    send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b1);
    idle_bits(2);
    send_frame(8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b1);
    idle_bits(2);
    wait_drain("drain_parity", 2000);

    // Six frames into a stalled 4-deep FIFO: two dropped with overrun.
    ready_val = 1'b0;
    o0 = ovr_cnt;
    for (int i = 1; i <= 6; i++)
      send_frame(8'(i), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, i <= DEPTH);
    idle_bits(2);
    check("overrun_pulses", ovr_cnt - o0, 2);
    check("full_valid", m_valid, 1);
    ready_val = 1'b1;
    wait_drain("drain_overrun", 2000);

    // Short start glitch: receiver must fall back to idle with nothing pushed.
    wait_ticks(1);
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    idle_bits(2);
    check("glitch_idle", rx_busy, 0);
    // Single-tick inversion mid data bit is voted out.
    send_frame(8'h6C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    idle_bits(2);
    send_frame(8'h93, 2'b01, 1'b0, good_pbit(8'h93, 2'b01), 1'b1, 1'b1, 0, 1'b1);
    idle_bits(2);
    wait_drain("drain_glitch", 2000);

    // Line held low for two frame times: one zero entry with frame error, one break pulse.
    b0 = brk_cnt;
    cfg_parity = 2'b00;
    cfg_two_stop = 1'b0;
    exp_q.push_back(model_ent('0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_brk++;
    wait_ticks(1);
    rx_in = 1'b0;
    wait_ticks(20 * OS);
    check("break_no_restart", rx_busy, 0);
    rx_in = 1'b1;
    idle_bits(2);
    wait_drain("drain_break", 2000);
    check("break_pulses", brk_cnt - b0, 1);

    // Two stop bits with the second one low.
    send_frame(8'h3C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b1);
    idle_bits(3);
    wait_drain("drain_two_stop", 2000);

    // Reset in the middle of the data bits with one entry waiting in the FIFO.
    ready_val = 1'b0;
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    idle_bits(1);
    check("pre_rst_valid", m_valid, 1);
    wait_ticks(1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    rx_in = 1'b1;
    wait_ticks(8);
    check("pre_rst_busy", rx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_busy_flags", {rx_busy, m_frame_err, m_parity_err, rx_overrun, rx_break}, 0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_val = 1'b1;
    idle_bits(2);
    check("post_rst_valid", m_valid, 0);
    send_frame(8'hC3, 2'b10, 1'b0, good_pbit(8'hC3, 2'b10), 1'b1, 1'b1, -1, 1'b1);
    idle_bits(2);
    wait_drain("drain_post_rst", 2000);

    // Randomised frames against the model, random consumer stalls.
    ready_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d  = ($urandom_range(0, 5) == 0) ? '0 : DB'($urandom);
      p  = 2'($urandom);
      ts = 1'($urandom);
      pb = good_pbit(d, p) ^ ($urandom_range(0, 3) == 0);
      if (d == '0 && $urandom_range(0, 1) == 0) pb = 1'b0;
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DB - 1)) : -1;
      gap = 2 + int'($urandom_range(0, 1));
      send_frame(d, p, ts, pb, s1, s2, gb, 1'b1);
      idle_bits(gap);
    end
    ready_rand = 1'b0;
    ready_val = 1'b1;
    idle_bits(1);
    wait_drain("drain_random", 4000);

    check("break_total", brk_cnt, exp_brk);
    check("overrun_total", ovr_cnt, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the team's 16x-oversampled UART receiver. Adds configurable data width and oversampling ratio, runtime parity and stop-bit modes, and 3-sample majority voting. Adds break detection and an output FIFO with a valid/ready handshake and overrun reporting. Sits between the baud generator tick and the byte-consuming logic (bus bridge or command parser).

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, rx_baud_tick pulses per bit; even, 8..32.
FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
rx_baud_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate.
rx_in  in  1  serial line; idles high.
cfg_parity  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
cfg_two_stop  in  1  1 = two stop bits checked.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  consumer accepts the head entry.
m_data  out  DATA_BITS  head entry data, LSB = first bit received.
m_frame_err  out  1  head entry had a stop bit sampled low.
m_parity_err  out  1  head entry parity mismatch; always 0 when parity is off.
rx_overrun  out  1  one-clk pulse when a completed frame is dropped because the FIFO is full.
rx_break  out  1  one-clk pulse on a break: data all 0, parity bit (if enabled) 0, first stop bit 0.
rx_busy  out  1  state machine is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - synchroniser flops set to 1; state IDLE; counters 0; FIFO emptied.
  - m_valid, m_data, m_frame_err, m_parity_err, rx_overrun, rx_break and rx_busy all 0.
  - Reset mid-frame aborts the frame; no partial entry is pushed.
- rx_in passes through a 2-FF synchroniser; all sampling uses the synchronised value (rxs).
- sample_cnt counts 0..OVERSAMPLE-1 on rx_baud_tick only and wraps to 0.
- Majority vote (V): rxs is captured at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; V = majority of the 3 samples, evaluated at tick OVERSAMPLE/2+1.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: when rxs == 0 -> START, sample_cnt cleared to 0. cfg_parity and cfg_two_stop are latched on this transition; changes mid-frame have no effect.
- START: if V == 1 -> IDLE (false start, nothing pushed). At tick OVERSAMPLE-1 -> DATA, bit_cnt = 0.
- DATA: V is shifted in LSB-first and computed parity updates. At the end of bit DATA_BITS-1 -> PARITY if parity is enabled, else STOP1.
- PARITY: expected parity bit = XOR of the data bits (even mode) or its inverse (odd mode). A mismatch sets the frame's parity flag. Then -> STOP1.
- STOP1: V == 0 sets the frame error flag.
  - With cfg_two_stop = 0: the frame is pushed on the clk after the vote, then -> IDLE. The receiver returns to IDLE half a bit early, so back-to-back frames resynchronise on the next falling edge.
  - With cfg_two_stop = 1: at tick OVERSAMPLE-1 -> STOP2.
- STOP2: V == 0 sets the frame error flag; push and -> IDLE exactly as for STOP1.
- Break: qualified at the STOP1 vote. Pulses rx_break on the same cycle as the push. The entry is still pushed with m_frame_err = 1. No new start is detected until rxs has been high for at least one clk.
- FIFO:
  - Entry = {parity_err, frame_err, data}. m_valid = not empty; the head is visible combinationally from FIFO storage.
  - Pop on m_valid && m_ready.
  - Push when full with no pop: the new frame is dropped, rx_overrun pulses, stored entries are unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Read and write pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Latency: last stop-bit vote tick -> push on the next clk -> m_valid high the clk after that (empty FIFO).
- rx_busy is high from leaving IDLE until returning to IDLE.

Test Plan:
- DATA_BITS=8, OVERSAMPLE=16, 8N1 frame 0xA5, m_ready=1 -> one entry: m_data=0xA5, both error flags 0; m_valid high 1 clk then low.
- 8E1 frame 0x03 with parity bit 1 (wrong) -> m_data=0x03, m_parity_err=1, m_frame_err=0. Same frame with odd mode -> m_parity_err=0.
- m_ready=0, 6 back-to-back 8N1 frames 0x01..0x06, FIFO_DEPTH=4 -> rx_overrun pulses twice; draining yields 0x01..0x04 in order.
- Start-bit glitch of rxs low for 4 ticks -> returns to IDLE, no push. Single-tick inversion at the centre of a data bit -> data still correct (vote).
- rx_in held low for 2 frame times -> one entry 0x00, m_frame_err=1, one rx_break pulse, no further entries until the line returns high.
- 2-stop mode, second stop bit low -> m_frame_err=1. Assert rst_n low mid-DATA -> all outputs 0 immediately and FIFO empty; the next clean frame is received correctly.
